load_store_unit: RTL and testbench

Memory-side responder to the decoder's MemRead/MemWrite/funct3 outputs. It takes one load or store per request and drives a single-port, word-wide data bus with a req/gnt/rvalid handshake. It forms byte enables and replicated write data, then aligns and sign- or zero-extends load data. It stalls the core until the access completes, faults or times out.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_align.sv | 25 ++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, LSU state type and lane helpers for the load/store unit.
// Pure declarations; no state, no timing.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << {off[1], 1'b0};
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_for(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] res;
        case (f3)
            F3_B:    res = {4{wd[7:0]}};
            F3_H:    res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        logic bad;
        if (is_store) begin
            bad = (f3 > F3_W);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data aligner: shifts the bus word down to the addressed lane and sign/zero extends.
// Purely combinational, zero latency, no handshake.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {24'd0, shifted[7:0]};
            F3_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store responder on a req/gnt/rvalid word bus.
// Min latency: load 3, store 2, error 1 cycle; stalls the core until done, with optional timeout abort.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        any_req;
    logic        bad_req;
    logic        timeout;
    logic [31:0] aligned;

    lsu_align u_align (
        .rdata_i  (bus_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (aligned)
    );

    assign any_req = mem_read_i | mem_write_i;
    assign bad_req = (mem_read_i & mem_write_i)
                   | f3_illegal(funct3_i, mem_write_i)
                   | misaligned(funct3_i, addr_i[1:0]);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (bad_req) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_i;
                        bus_addr_d  = {addr_i[31:2], 2'b00};
                        bus_be_d    = be_for(funct3_i, addr_i[1:0]);
                        bus_wdata_d = wdata_for(funct3_i, wdata_i);
                        f3_d        = funct3_i;
                        off_d       = addr_i[1:0];
                        cnt_d       = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (timeout) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid_i) begin
                    rdata_d = aligned;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (timeout) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    // Stall must rise in the accept cycle itself, so it is decoded from live inputs.
    assign stall_o = ((state_q == S_IDLE) & any_req & ~rst_i)
                   | (state_q == S_REQ) | (state_q == S_RESP);

    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, error cases, timeout and mid-op reset.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        bus_gnt_i   = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    // Store with grant in the first request cycle.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        mem_write_i = 1'b1;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wd;
        #1 check({tag, " stall@0"}, 32'(stall_o), 32'd1);
        tick();
        check({tag, " req@1"}, 32'(bus_req_o), 32'd1);
        check({tag, " we@1"}, 32'(bus_we_o), 32'd1);
        check({tag, " addr"}, bus_addr_o, {addr[31:2], 2'b00});
        check({tag, " be"}, 32'(bus_be_o), 32'(exp_be));
        check({tag, " wdata"}, bus_wdata_o, exp_wd);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i   = 1'b0;
        mem_write_i = 1'b0;
        check({tag, " done@2"}, 32'(done_o), 32'd1);
        check({tag, " err@2"}, 32'(err_o), 32'd0);
        check({tag, " req@2"}, 32'(bus_req_o), 32'd0);
        check({tag, " stall@2"}, 32'(stall_o), 32'd0);
        tick();
        check({tag, " done@3"}, 32'(done_o), 32'd0);
    endtask

    // Load with grant at cycle 1 and rvalid at cycle 2.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] bus_word, input logic [3:0] exp_be,
                           input logic [31:0] exp_rd);
        mem_read_i = 1'b1;
        funct3_i   = f3;
        addr_i     = addr;
        tick();
        check({tag, " req@1"}, 32'(bus_req_o), 32'd1);
        check({tag, " we@1"}, 32'(bus_we_o), 32'd0);
        check({tag, " be"}, 32'(bus_be_o), 32'(exp_be));
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        check({tag, " req@2"}, 32'(bus_req_o), 32'd0);
        check({tag, " stall@2"}, 32'(stall_o), 32'd1);
        check({tag, " done@2"}, 32'(done_o), 32'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = bus_word;
        tick();
        bus_rvalid_i = 1'b0;
        mem_read_i   = 1'b0;
        check({tag, " done@3"}, 32'(done_o), 32'd1);
        check({tag, " err@3"}, 32'(err_o), 32'd0);
        check({tag, " rdata"}, rdata_o, exp_rd);
        tick();
        check({tag, " done@4"}, 32'(done_o), 32'd0);
        check({tag, " rdata hold"}, rdata_o, exp_rd);
    endtask

    task automatic do_error(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = addr;
        tick();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        check({tag, " req"}, 32'(bus_req_o), 32'd0);
        check({tag, " done@1"}, 32'(done_o), 32'd1);
        check({tag, " err@1"}, 32'(err_o), 32'd1);
        tick();
        check({tag, " done@2"}, 32'(done_o), 32'd0);
        check({tag, " err@2"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        idle_inputs();
        funct3_i    = 3'd0;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        bus_rdata_i = 32'd0;
        tick();
        tick();
        check("rst req", 32'(bus_req_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst rdata", rdata_o, 32'd0);
        check("rst stall", 32'(stall_o), 32'd0);
        check("rst be", 32'(bus_be_o), 32'd0);
        rst_i = 1'b0;
        tick();

        do_store("sw", 3'd2, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
        do_store("sb", 3'd0, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
        do_store("sh", 3'd1, 32'h102, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF);

        do_load("lb",  3'd0, 32'h102, 32'h1280FF00, 4'b0100, 32'hFFFFFF80);
        do_load("lbu", 3'd4, 32'h102, 32'h1280FF00, 4'b0100, 32'h00000080);
        do_load("lh",  3'd1, 32'h102, 32'h1280FF00, 4'b1100, 32'h00001280);
        do_load("lh0", 3'd1, 32'h100, 32'h12348001, 4'b0011, 32'hFFFF8001);
        do_load("lhu", 3'd5, 32'h100, 32'h12348001, 4'b0011, 32'h00008001);
        do_load("lw",  3'd2, 32'h104, 32'h12345678, 4'hF,    32'h12345678);

        do_error("lw misalign", 1'b1, 1'b0, 3'd2, 32'h102);
        do_error("rd+wr",       1'b1, 1'b1, 3'd2, 32'h100);
        do_error("lh odd",      1'b1, 1'b0, 3'd1, 32'h101);
        do_error("ld f3=6",     1'b1, 1'b0, 3'd6, 32'h100);
        do_error("st f3=4",     1'b0, 1'b1, 3'd4, 32'h100);
        check("err keeps rdata", rdata_o, 32'h12345678);

        // Grant never arrives: request held 4 cycles, then timeout abort.
        mem_read_i = 1'b1;
        funct3_i   = 3'd2;
        addr_i     = 32'h200;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("to req@%0d", i), 32'(bus_req_o), 32'd1);
            check($sformatf("to done@%0d", i), 32'(done_o), 32'd0);
        end
        tick();
        mem_read_i = 1'b0;
        check("to done", 32'(done_o), 32'd1);
        check("to err", 32'(err_o), 32'd1);
        check("to req drop", 32'(bus_req_o), 32'd0);
        check("to rdata kept", rdata_o, 32'h12345678);
        tick();
        check("to done clr", 32'(done_o), 32'd0);

        // Reset while waiting for read data; the late rvalid must be ignored.
        mem_read_i = 1'b1;
        funct3_i   = 3'd0;
        addr_i     = 32'h102;
        tick();
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i  = 1'b0;
        mem_read_i = 1'b0;
        check("rr stall in resp", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i        = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1280FF00;
        check("rr req", 32'(bus_req_o), 32'd0);
        check("rr stall", 32'(stall_o), 32'd0);
        check("rr rdata", rdata_o, 32'd0);
        tick();
        bus_rvalid_i = 1'b0;
        check("rr done", 32'(done_o), 32'd0);
        check("rr rdata after", rdata_o, 32'd0);
        tick();
        check("rr done later", 32'(done_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
